// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encodings, default operand width and small decode helpers.
package mult_div_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the datapath control and the multiply/divide
// unit; the datapath side is the master.
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  logic             Start;
  logic [1:0]       MDOp;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] WrData;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, MDOp, In1, In2, HiWrite, LoWrite, WrData,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, MDOp, In1, In2, HiWrite, LoWrite, WrData,
    output Busy, Done, Hi, Lo
  );

endinterface

// File: rtl/mult_div_unit_abs.sv
// Combinational conditional two's-complement negate; yields the magnitude of a
// signed value when neg_i is its sign bit, or applies a result sign.
module mult_div_unit_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing HI/LO: unsigned magnitude
// iterations (shift-add / restoring shift-subtract) followed by sign correction.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave md
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state_q;
  md_op_e             op_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  md_op_e             op_in;
  logic               sgn_in;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  logic [WIDTH:0]     mul_upper;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;

  assign op_in  = md_op_e'(md.MDOp);
  assign sgn_in = op_is_signed(op_in);

  mult_div_unit_abs #(.W(WIDTH)) u_abs_in1 (
    .val_i (md.In1),
    .neg_i (sgn_in & md.In1[WIDTH-1]),
    .res_o (mag1)
  );

  mult_div_unit_abs #(.W(WIDTH)) u_abs_in2 (
    .val_i (md.In2),
    .neg_i (sgn_in & md.In2[WIDTH-1]),
    .res_o (mag2)
  );

  mult_div_unit_abs #(.W(2*WIDTH)) u_abs_prod (
    .val_i (acc_q),
    .neg_i (neg_res_q),
    .res_o (prod_fix)
  );

  mult_div_unit_abs #(.W(WIDTH)) u_abs_quo (
    .val_i (acc_q[WIDTH-1:0]),
    .neg_i (neg_res_q),
    .res_o (quo_fix)
  );

  mult_div_unit_abs #(.W(WIDTH)) u_abs_rem (
    .val_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (neg_rem_q),
    .res_o (rem_fix)
  );

  // One iteration step. Multiply keeps the multiplier in the low half and shifts
  // the partial product in from the top; divide keeps the remainder in the high
  // half and shifts quotient bits in at the bottom.
  always_comb begin
    mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      mul_upper = mul_upper + {1'b0, opnd_q};
    end
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    if (op_is_div(op_q)) begin
      acc_d = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end else begin
      acc_d = {mul_upper, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (md.HiWrite) hi_q <= md.WrData;
          if (md.LoWrite) lo_q <= md.WrData;
          if (md.Start) begin
            op_q      <= op_in;
            opnd_q    <= op_is_div(op_in) ? mag2 : mag1;
            acc_q     <= {{WIDTH{1'b0}}, (op_is_div(op_in) ? mag1 : mag2)};
            neg_res_q <= sgn_in & (md.In1[WIDTH-1] ^ md.In2[WIDTH-1]);
            neg_rem_q <= sgn_in & md.In1[WIDTH-1];
            dz_q      <= (md.In2 == '0);
            count_q   <= CW'(WIDTH - 1);
            busy_q    <= 1'b1;
            state_q   <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q   <= acc_d;
          count_q <= count_q - CW'(1);
          if (count_q == '0) state_q <= S_SIGN;
        end
        S_SIGN: begin
          // A zero divisor leaves an all-ones quotient that must not be negated.
          if (op_is_div(op_q)) begin
            hi_q <= rem_fix;
            lo_q <= dz_q ? '1 : quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md.Busy = busy_q;
  assign md.Done = done_q;
  assign md.Hi   = hi_q;
  assign md.Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit against a plain-arithmetic
// HI/LO reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0]   exp_hi = '0;
  logic [W-1:0]   exp_lo = '0;
  logic [2*W-1:0] r_tmp;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {HI, LO} from the architectural definition of each operation.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [31:0] uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    if (op == 2'b00) begin
      res = sa * sb;
    end else if (op == 2'b01) begin
      res = {32'b0, a} * {32'b0, b};
    end else if (b == 32'h0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      uq = a / b;
      ur = a % b;
      res = {ur, uq};
    end
    return res;
  endfunction

  task automatic clear_inputs();
    bus.Start   = 1'b0;
    bus.HiWrite = 1'b0;
    bus.LoWrite = 1'b0;
    bus.In1     = $urandom;
    bus.In2     = $urandom;
    bus.MDOp    = 2'($urandom);
    bus.WrData  = $urandom;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit wr, input logic [31:0] wd);
    @(negedge clk);
    bus.Start   = 1'b1;
    bus.MDOp    = op;
    bus.In1     = a;
    bus.In2     = b;
    bus.HiWrite = wr;
    bus.LoWrite = wr;
    bus.WrData  = wd;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int n = 0;
    while (bus.Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
    check({tag, " done"}, 64'(bus.Done), 64'(1));
    check({tag, " hi"}, 64'(bus.Hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.Lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, " done_clear"}, 64'(bus.Done), 64'(0));
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit wr, input string tag);
    logic [63:0] r;
    logic [31:0] wd;
    r  = ref_model(op, a, b);
    wd = $urandom;
    start_op(op, a, b, wr, wd);
    if (wr) check({tag, " lo_write_at_start"}, 64'(bus.Lo), 64'(wd));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    wait_done(tag, W + 1);
  endtask

  task automatic mt(input bit hi, input logic [31:0] d);
    @(negedge clk);
    bus.HiWrite = hi;
    bus.LoWrite = ~hi;
    bus.WrData  = d;
    @(negedge clk);
    clear_inputs();
    if (hi) exp_hi = d;
    else    exp_lo = d;
    check("mt hi", 64'(bus.Hi), 64'(exp_hi));
    check("mt lo", 64'(bus.Lo), 64'(exp_lo));
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          sel;
    int          pulses;

    bus.Start = 1'b0; bus.MDOp = 2'b00; bus.In1 = '0; bus.In2 = '0;
    bus.HiWrite = 1'b0; bus.LoWrite = 1'b0; bus.WrData = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.Busy), 64'(0));
    check("reset done", 64'(bus.Done), 64'(0));
    check("reset hi", 64'(bus.Hi), 64'(0));
    check("reset lo", 64'(bus.Lo), 64'(0));
    reset = 1'b1;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, "mult_neg3x7");
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg7by2");
    do_op(2'b11, 32'h0000_0007, 32'h0000_0002, 1'b0, "divu_7by2");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    do_op(2'b11, 32'h0000_0005, 32'h0000_0000, 1'b0, "divu_by0");
    do_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, "div_neg_by0");
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");

    mt(1'b0, 32'h0000_1234);
    mt(1'b1, 32'hCAFE_F00D);

    // Start and MTHI arriving mid-operation must both be ignored.
    r_tmp  = ref_model(2'b01, 32'h0001_0003, 32'h0000_0100);
    exp_hi = r_tmp[63:32];
    exp_lo = r_tmp[31:0];
    start_op(2'b01, 32'h0001_0003, 32'h0000_0100, 1'b0, 32'h0);
    repeat (9) @(negedge clk);
    bus.Start   = 1'b1;
    bus.MDOp    = 2'b10;
    bus.HiWrite = 1'b1;
    bus.WrData  = 32'hDEAD_BEEF;
    @(negedge clk);
    clear_inputs();
    wait_done("start_while_busy", W + 1 - 10);

    do_op(2'b10, 32'h8765_4321, 32'h0000_0123, 1'b1, "write_with_start");

    for (int i = 0; i < 30; i++) begin
      op  = 2'($urandom);
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
        3: b = $urandom_range(0, 3);
        default: ;
      endcase
      do_op(op, a, b, (sel == 4), $sformatf("rnd%0d", i));
      if (sel == 5) mt(1'($urandom_range(0, 1)), $urandom);
    end

    // Reset part-way through a divide: result discarded, no Done afterwards.
    start_op(2'b10, 32'h7FFF_0001, 32'h0000_0013, 1'b0, 32'h0);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    check("midreset busy", 64'(bus.Busy), 64'(0));
    check("midreset done", 64'(bus.Done), 64'(0));
    check("midreset hi", 64'(bus.Hi), 64'(0));
    check("midreset lo", 64'(bus.Lo), 64'(0));
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) pulses++;
    end
    check("midreset no_done", 64'(pulses), 64'(0));

    do_op(2'b00, $urandom, $urandom, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
